// File: rtl/cycle_counter.sv
// Processor cycle counter feeding the four-digit display stage: counts cpu_step
// strobes while running, refreshes the shown value periodically, freezes on halt.
module cycle_counter #(
  parameter int unsigned MAX_COUNT  = 9999,
  parameter int unsigned UPDATE_DIV = 1000000,
  parameter int unsigned DIV_W      = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        clear_btn,
  input  logic        cpu_step,
  input  logic        cpu_halt,
  output logic [15:0] displayed_number,
  output logic        running,
  output logic        halted,
  output logic        overflow
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [15:0]      MAX_C    = 16'(MAX_COUNT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(UPDATE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  state_t           state_q, state_d;
  logic [15:0]      count_q, count_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [15:0]      disp_q, disp_d;
  logic             ovf_q, ovf_d;
  logic             running_q, halted_q;

  // Bits [1:0] synchronize the raw button, bit [2] is the edge-detect history.
  logic [2:0] start_sync_q;
  logic [2:0] clear_sync_q;
  logic       start_pulse;
  logic       clear_pulse;

  assign start_pulse = start_sync_q[1] & ~start_sync_q[2];
  assign clear_pulse = clear_sync_q[1] & ~clear_sync_q[2];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    div_d   = div_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    if (clear_pulse) begin
      state_d = S_IDLE;
      count_d = '0;
      div_d   = '0;
      disp_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_pulse) begin
            state_d = S_RUN;
            count_d = '0;
            div_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        S_RUN: begin
          if (cpu_step) begin
            if (count_q == MAX_C) ovf_d = 1'b1;
            else                  count_d = count_q + 16'd1;
          end
          // A halt snapshots the count including a coincident step; the
          // divider is left alone since any restart zeroes it.
          if (cpu_halt) begin
            state_d = S_HALTED;
            disp_d  = count_d;
          end else if (div_q == DIV_LAST) begin
            div_d  = '0;
            disp_d = count_d;
          end else begin
            div_d = div_q + DIV_ONE;
          end
        end
        S_HALTED: begin
          if (start_pulse) begin
            state_d = S_RUN;
            count_d = '0;
            div_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      div_q        <= '0;
      disp_q       <= '0;
      ovf_q        <= 1'b0;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
      start_sync_q <= '0;
      clear_sync_q <= '0;
    end else begin
      start_sync_q <= {start_sync_q[1:0], start_btn};
      clear_sync_q <= {clear_sync_q[1:0], clear_btn};
      state_q      <= state_d;
      count_q      <= count_d;
      div_q        <= div_d;
      disp_q       <= disp_d;
      ovf_q        <= ovf_d;
      running_q    <= (state_d == S_RUN);
      halted_q     <= (state_d == S_HALTED);
    end
  end

  assign displayed_number = disp_q;
  assign running          = running_q;
  assign halted           = halted_q;
  assign overflow         = ovf_q;

endmodule

// File: doc/cycle_counter.md
Name: cycle_counter

Overview:
Counts executed processor cycles for the 8-bit processor and supplies the 16-bit binary value that the four-digit seven-segment display stage converts and multiplexes. Board push-buttons start and clear the measurement. The processor core supplies a per-cycle step strobe and a halt flag. The displayed value is refreshed at a slow, flicker-free rate, frozen on halt, and saturated at the largest four-digit decimal value.

Parameters:
MAX_COUNT, 9999, saturation ceiling for the count (must be ≤ 65535); 9999 keeps the value within four decimal digits.
UPDATE_DIV, 1000000, clk cycles between display refreshes while running (10 ms at 100 MHz); must be ≥ 2.
DIV_W, 20, width of the refresh divider; must satisfy 2^DIV_W ≥ UPDATE_DIV.

Ports:
clk  input  1  main system clock (100 MHz)
reset  input  1  asynchronous, active-high reset
start_btn  input  1  raw start push-button, asynchronous to clk, active-high
clear_btn  input  1  raw clear push-button, asynchronous to clk, active-high
cpu_step  input  1  high for one clk per executed processor cycle; synchronous to clk
cpu_halt  input  1  processor halted (level); synchronous to clk
displayed_number  output  16  binary count presented to the display stage
running  output  1  high in RUN
halted  output  1  high in HALTED
overflow  output  1  a step arrived while the count was at MAX_COUNT

Behaviour:
- Reset (async, high): state=IDLE; count, divider, sync flops, displayed_number, overflow = 0; running = halted = 0.
- Button conditioning: each button goes through a 2-flop synchronizer plus a third flop for edge detection. pulse = sync2 & ~sync3.
- Pulse latency: if a button is first sampled high at edge k, the pulse is high in the cycle after edge k+1 and acts at edge k+2. A held button yields exactly one pulse. No debounce is performed in this block.
- The FSM has three states: IDLE, RUN, HALTED.
  - IDLE: count held at 0. start pulse -> RUN with count=0, divider=0, overflow=0. cpu_step and cpu_halt are ignored.
  - RUN, increment: cpu_step=1 -> count+1, unless count==MAX_COUNT; then count holds and overflow<=1.
  - RUN, halt: cpu_halt=1 -> HALTED. A cpu_step in the same cycle is still counted. On that edge, displayed_number <= the post-increment count.
  - RUN, start pulse: ignored.
  - HALTED: count and displayed_number frozen; cpu_step ignored. start pulse -> RUN with count=0, divider=0, overflow=0; displayed_number holds until the next refresh.
  - Any state, clear pulse: -> IDLE; count, divider, displayed_number, overflow = 0 on the same edge.
- Simultaneous start and clear pulses: clear wins.
- Refresh divider counts 0..UPDATE_DIV-1 only in RUN. At the edge where it equals UPDATE_DIV-1 it wraps to 0 and displayed_number <= the next-state count, including any step on that edge.
- displayed_number changes only on: refresh wrap, entry to HALTED, clear, or reset.
- Count is 16 bits unsigned and never exceeds MAX_COUNT. overflow is sticky until clear, restart, or reset.
- running and halted are registered and decoded from state; they are never both high.
- Reset mid-run aborts immediately with no partial update.

Test Plan (UPDATE_DIV=4, MAX_COUNT=9999 unless noted):
- Reset, then pulse start_btn for 1 cycle -> running rises 3 edges after first sample; displayed_number=0; overflow=0.
- RUN with cpu_step high continuously for 10 cycles, then cpu_halt -> halted=1, running=0. displayed_number=10 on the halt edge, plus 1 if a step coincides with halt. Further steps leave the value unchanged.
- RUN with steps every cycle -> displayed_number updates only every 4th clk, with values 4, 8, 12; it is constant between updates.
- MAX_COUNT=5, 8 steps in RUN -> count stops at 5; overflow=1 from the 6th step. Clear -> displayed_number=0, overflow=0, IDLE.
- start_btn and clear_btn asserted on the same cycle while HALTED with count 37 -> IDLE, displayed_number=0. start_btn held high 50 cycles -> exactly one transition to RUN.
- Assert reset mid-RUN at count 123 -> all outputs 0 asynchronously. cpu_step after reset release, without a start pulse -> count stays 0.
